bird_motion_ctrl: RTL and testbench

- Generates the bird's on-screen centre position and animation state once per video frame, for the bird sprite ROM interface.
- The bird moves under gravity and a flap impulse from the player button.
- Handles start, play and death, including the fall to the ground after a collision.
- Outputs feed the sprite ROM interface (centre coordinates, 2-bit state) and the pipe/collision logic.

---
 rtl/bird_motion_ctrl_if.sv | 21 ++
 rtl/bird_motion_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bird_motion_ctrl_if.sv
// Bird motion controller bus: frame/button/collision inputs and sprite-facing outputs.
interface bird_motion_ctrl_if;
  logic        frame_tick;
  logic        flap_btn;
  logic        collide;
  logic [10:0] bird_h_out;
  logic [10:0] bird_v_out;
  logic [1:0]  state_output;
  logic        alive;
  logic        dead_pulse;

  modport master (
    output frame_tick, flap_btn, collide,
    input  bird_h_out, bird_v_out, state_output, alive, dead_pulse
  );

  modport slave (
    input  frame_tick, flap_btn, collide,
    output bird_h_out, bird_v_out, state_output, alive, dead_pulse
  );
endinterface

// File: rtl/bird_motion_ctrl.sv
// Per-frame bird position/animation state: gravity, flap impulse, play/death/restart.
// Optional idle bobbing animation enabled by defining BIRD_IDLE_BOB_EN.
module bird_motion_ctrl #(
    parameter int BIRD_X    = 160,
    parameter int START_Y   = 240,
    parameter int GRAVITY   = 1,
    parameter int FLAP_VEL  = 8,
    parameter int MAX_FALL  = 10,
    parameter int CEIL_Y    = 16,
    parameter int GROUND_Y  = 416,
    parameter int DEAD_HOLD = 60
) (
    input logic               clk,
    input logic               rst,
    bird_motion_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_e;

    localparam int HW = $clog2(DEAD_HOLD + 1);
    localparam logic signed [11:0] TOP_LIM  = 12'(CEIL_Y + 16);
    localparam logic signed [11:0] BOT_LIM  = 12'(GROUND_Y - 16);
    localparam logic [10:0]        START_V  = 11'(START_Y);
    localparam logic [10:0]        GROUND_V = 11'(GROUND_Y - 16);
    localparam logic signed [7:0]  FLAP_V   = -8'(FLAP_VEL);
    localparam logic signed [7:0]  GRAV_V   = 8'(GRAVITY);
    localparam logic signed [7:0]  MAXF_V   = 8'(MAX_FALL);
    localparam logic [HW-1:0]      HOLD_MAX = HW'(DEAD_HOLD);

    state_e             state_q, state_d;
    logic [10:0]        bird_v_q, bird_v_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               pend_q, pend_d;
    logic [2:0]         sync_q;
    logic [1:0]         sout_q, sout_d;
    logic               alive_q, dead_pulse_q;

    logic               flap_evt, grounded, hit_ground;
    logic signed [7:0]  vel_eff, vel_inc, phys_vel;
    logic signed [11:0] next_pos;
    logic [10:0]        phys_v;

`ifdef BIRD_IDLE_BOB_EN
    logic [3:0] bob_cnt_q, bob_cnt_d;
    logic       bob_dn_q, bob_dn_d;
`endif

    // sync_q[1] is the second synchronizer stage, sync_q[2] its previous value
    assign flap_evt = sync_q[1] & ~sync_q[2];
    assign grounded = (bird_v_q == GROUND_V);

    // Shared gravity/clamp step; in DEAD the velocity is floored at 0 so the bird only falls
    always_comb begin
        vel_eff = vel_q;
        if (state_q == PLAY) begin
            if (pend_q) vel_eff = FLAP_V;
        end else if (vel_q < 0) begin
            vel_eff = '0;
        end
        next_pos = $signed({1'b0, bird_v_q}) + $signed({{4{vel_eff[7]}}, vel_eff});
        vel_inc  = vel_eff + GRAV_V;
        phys_v     = next_pos[10:0];
        phys_vel   = (vel_inc > MAXF_V) ? MAXF_V : vel_inc;
        hit_ground = 1'b0;
        if (next_pos < TOP_LIM) begin
            phys_v   = TOP_LIM[10:0];
            phys_vel = '0;
        end else if (next_pos >= BOT_LIM) begin
            phys_v     = GROUND_V;
            phys_vel   = '0;
            hit_ground = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        bird_v_d = bird_v_q;
        vel_d    = vel_q;
        hold_d   = hold_q;
`ifdef BIRD_IDLE_BOB_EN
        bob_cnt_d = bob_cnt_q;
        bob_dn_d  = bob_dn_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef BIRD_IDLE_BOB_EN
                if (bus.frame_tick && !pend_q) begin
                    bob_cnt_d = bob_cnt_q + 4'd1;
                    if (bob_cnt_q[0]) begin
                        if (bob_dn_q && bird_v_q == START_V + 11'd4) begin
                            bob_dn_d = 1'b0;
                            bird_v_d = bird_v_q - 11'd1;
                        end else if (!bob_dn_q && bird_v_q == START_V - 11'd4) begin
                            bob_dn_d = 1'b1;
                            bird_v_d = bird_v_q + 11'd1;
                        end else begin
                            bird_v_d = bob_dn_q ? bird_v_q + 11'd1 : bird_v_q - 11'd1;
                        end
                    end
                end
`else
                bird_v_d = START_V;
`endif
                if (bus.frame_tick && pend_q) begin
                    vel_d   = FLAP_V;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.collide) begin
                    state_d = DEAD;
                end else if (bus.frame_tick) begin
                    bird_v_d = phys_v;
                    vel_d    = phys_vel;
                    if (hit_ground) state_d = DEAD;
                end
            end
            DEAD: begin
                if (bus.frame_tick) begin
                    if (!grounded) begin
                        bird_v_d = phys_v;
                        vel_d    = phys_vel;
                    end else if (hold_q == HOLD_MAX && pend_q) begin
                        bird_v_d = START_V;
                        vel_d    = '0;
                        hold_d   = '0;
                        state_d  = IDLE;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BIRD_IDLE_BOB_EN
        if (state_d != IDLE) begin
            bob_cnt_d = '0;
            bob_dn_d  = 1'b1;
        end
`endif

        // A tick skipped because of a collision does not consume the pending flap
        pend_d = pend_q;
        if (bus.frame_tick && !(state_q == PLAY && bus.collide)) pend_d = 1'b0;
        if (flap_evt) pend_d = 1'b1;

        unique case (state_d)
            PLAY:    sout_d = (vel_d < 0) ? 2'd1 : 2'd2;
            DEAD:    sout_d = 2'd3;
`ifdef BIRD_IDLE_BOB_EN
            default: sout_d = bob_dn_d ? 2'd2 : 2'd1;
`else
            default: sout_d = 2'd0;
`endif
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bird_v_q     <= START_V;
            vel_q        <= '0;
            hold_q       <= '0;
            pend_q       <= 1'b0;
            sync_q       <= '0;
            sout_q       <= '0;
            alive_q      <= 1'b0;
            dead_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bird_v_q     <= bird_v_d;
            vel_q        <= vel_d;
            hold_q       <= hold_d;
            pend_q       <= pend_d;
            sync_q       <= {sync_q[1:0], bus.flap_btn};
            sout_q       <= sout_d;
            alive_q      <= (state_d == PLAY);
            dead_pulse_q <= (state_d == DEAD) && (state_q != DEAD);
        end
    end

`ifdef BIRD_IDLE_BOB_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bob_cnt_q <= '0;
            bob_dn_q  <= 1'b1;
        end else begin
            bob_cnt_q <= bob_cnt_d;
            bob_dn_q  <= bob_dn_d;
        end
    end
`endif

    assign bus.bird_h_out   = 11'(BIRD_X);
    assign bus.bird_v_out   = bird_v_q;
    assign bus.state_output = sout_q;
    assign bus.alive        = alive_q;
    assign bus.dead_pulse   = dead_pulse_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl (default build) with hand-computed trajectories.
module tb_bird_motion_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    bird_motion_ctrl_if bif();

    bird_motion_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One idle cycle, then a single-cycle frame_tick; returns 1 time unit after the tick edge
    task automatic frame();
        @(posedge clk); #1;
        bif.frame_tick = 1'b1;
        @(posedge clk); #1;
        bif.frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press();
        bif.flap_btn = 1'b1;
        repeat (4) @(posedge clk);
        #1 bif.flap_btn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bif.frame_tick = 1'b0;
        bif.flap_btn   = 1'b0;
        bif.collide    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_v", bif.bird_v_out, 240);
        check("rst_h", bif.bird_h_out, 160);
        check("rst_state", bif.state_output, 0);
        check("rst_alive", bif.alive, 0);
        check("rst_dpulse", bif.dead_pulse, 0);

        frames(5);
        check("idle_v", bif.bird_v_out, 240);
        check("idle_state", bif.state_output, 0);
        check("idle_alive", bif.alive, 0);

        // Start and free flight to the ground
        press();
        frame();
        check("t1_v", bif.bird_v_out, 240);
        check("t1_alive", bif.alive, 1);
        check("t1_state", bif.state_output, 1);
        frame(); check("t2_v", bif.bird_v_out, 232);
        frame(); check("t3_v", bif.bird_v_out, 225);
        frame(); check("t4_v", bif.bird_v_out, 219);
        check("t4_state", bif.state_output, 1);
        frames(6);
        check("t10_v", bif.bird_v_out, 204);
        check("t10_state", bif.state_output, 2);
        frames(9);
        check("t19_v", bif.bird_v_out, 249);
        frames(15);
        check("t34_v", bif.bird_v_out, 399);
        check("t34_alive", bif.alive, 1);
        frame();
        check("gnd_v", bif.bird_v_out, 400);
        check("gnd_state", bif.state_output, 3);
        check("gnd_alive", bif.alive, 0);
        check("gnd_dpulse", bif.dead_pulse, 1);
        @(posedge clk); #1;
        check("gnd_dpulse_off", bif.dead_pulse, 0);

        // Restart hold window
        frames(30);
        press(); frame();
        check("early_press_state", bif.state_output, 3);
        check("early_press_v", bif.bird_v_out, 400);
        frames(28);
        press(); frame();
        check("hold59_state", bif.state_output, 3);
        press(); frame();
        check("restart_state", bif.state_output, 0);
        check("restart_v", bif.bird_v_out, 240);
        check("restart_alive", bif.alive, 0);
        frame();
        check("restart_no_play", bif.state_output, 0);
        bif.collide = 1'b1;
        frame();
        bif.collide = 1'b0;
        check("idle_collide_state", bif.state_output, 0);
        check("idle_collide_alive", bif.alive, 0);

        // Repeated flaps into the ceiling
        press(); frame();
        check("play2_v", bif.bird_v_out, 240);
        for (int i = 0; i < 26; i++) begin
            press(); frame();
        end
        check("ceil_reach_v", bif.bird_v_out, 32);
        check("ceil_reach_state", bif.state_output, 1);
        press(); frame();
        check("ceil_clamp_v", bif.bird_v_out, 32);
        check("ceil_clamp_state", bif.state_output, 2);
        frame();
        check("ceil_rest_v", bif.bird_v_out, 32);
        frame();
        check("ceil_fall_v", bif.bird_v_out, 33);

        // Collision coinciding with frame_tick skips that update
        @(posedge clk); #1;
        bif.collide    = 1'b1;
        bif.frame_tick = 1'b1;
        @(posedge clk); #1;
        bif.collide    = 1'b0;
        bif.frame_tick = 1'b0;
        check("col_v", bif.bird_v_out, 33);
        check("col_state", bif.state_output, 3);
        check("col_dpulse", bif.dead_pulse, 1);
        press(); frame();
        check("dfall1_v", bif.bird_v_out, 35);
        frames(8);
        check("dfall9_v", bif.bird_v_out, 87);
        frames(31);
        check("dfall40_v", bif.bird_v_out, 397);
        frame();
        check("dfall41_v", bif.bird_v_out, 400);
        check("dfall41_state", bif.state_output, 3);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst2_v", bif.bird_v_out, 240);

        // Double press in one frame, then a held button
        press(); press(); frame();
        check("dbl_state", bif.state_output, 1);
        frame(); check("dbl_t2_v", bif.bird_v_out, 232);
        frame(); check("dbl_t3_v", bif.bird_v_out, 225);
        bif.flap_btn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        frames(3);
        bif.flap_btn = 1'b0;
        check("held_v", bif.bird_v_out, 204);
        check("held_state", bif.state_output, 1);

        // Collision without a tick, fall starts at zero velocity, async reset mid-fall
        @(posedge clk); #1;
        bif.collide = 1'b1;
        @(posedge clk); #1;
        bif.collide = 1'b0;
        check("col2_state", bif.state_output, 3);
        check("col2_dpulse", bif.dead_pulse, 1);
        check("col2_v", bif.bird_v_out, 204);
        frame(); check("dfall_norise_v", bif.bird_v_out, 204);
        frame(); check("dfall_grav_v", bif.bird_v_out, 205);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_v", bif.bird_v_out, 240);
        check("arst_state", bif.state_output, 0);
        check("arst_alive", bif.alive, 0);
        @(posedge clk); #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
